// File: rtl/window_gen_if.sv
// window_gen_if: groups the start/read/window signals of window_gen.
// slave  = window_gen side, master = image memory / filter side.
interface window_gen_if #(
    parameter int DW = 8,
    parameter int AW = 17
);
    logic              en;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic [9*DW-1:0]   win;
    logic              win_valid;
    logic [7:0]        out_row;
    logic [7:0]        out_col;
    logic              busy;
    logic              done;

    modport slave (
        input  en, rd_data,
        output rd_en, rd_addr, win, win_valid, out_row, out_col, busy, done
    );

    modport master (
        output en, rd_data,
        input  rd_en, rd_addr, win, win_valid, out_row, out_col, busy, done
    );
endinterface

// File: rtl/window_gen.sv
// window_gen: streaming 3x3 neighbourhood generator over a padded image.
// Scans PWxPH positions row-major, keeps two line buffers, emits one
// window per output pixel tagged with its output coordinate.
// Optional macro WINDOW_GEN_BORDER_EN: the source is the unpadded image and
// border positions inject zero instead of being read.
//
// state   | meaning
// S_IDLE  | waiting for en, all outputs 0
// S_SCAN  | issuing one read per cycle, index k = row*PW + col
// S_DRAIN | waiting for the last two pipeline stages, then pulse done
module window_gen #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int DW    = 8,
    parameter int AW    = 17
) (
    input  logic        clk,
    input  logic        rst,
    window_gen_if.slave bus
);
    localparam int PW = IMG_W + 2;
    localparam int PH = IMG_H + 2;
    localparam int CW = $clog2(PW);
    localparam int RW = $clog2(PH);

`ifdef WINDOW_GEN_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

    state_t          r_state;
    logic [RW-1:0]   r_row;
    logic [CW-1:0]   r_col;
    logic            r_issue;
    logic            r_rd_en;
    logic            r_zero;
    logic [AW-1:0]   r_rd_addr;
    logic            r_drain;
    logic            r_busy;
    logic            r_done;

    logic            r_p1_vld;
    logic            r_p1_zero;
    logic [RW-1:0]   r_p1_row;
    logic [CW-1:0]   r_p1_col;

    logic [9*DW-1:0] r_sh;
    logic [9*DW-1:0] r_win;
    logic            r_win_valid;
    logic [7:0]      r_out_row;
    logic [7:0]      r_out_col;

    logic [DW-1:0]   r_lb0 [PW];
    logic [DW-1:0]   r_lb1 [PW];

    logic            w_last_col;
    logic            w_last;
    logic [RW-1:0]   w_nrow;
    logic [CW-1:0]   w_ncol;
    logic            w_nb;
    logic [DW-1:0]   w_pix;
    logic            w_win_ok;
    logic [RW-1:0]   w_orow;
    logic [CW-1:0]   w_ocol;
    logic [9*DW-1:0] w_sh_next;

    assign w_last_col = (r_col == CW'(PW - 1));
    assign w_last     = w_last_col && (r_row == RW'(PH - 1));
    assign w_nrow     = w_last_col ? r_row + RW'(1) : r_row;
    assign w_ncol     = w_last_col ? '0 : r_col + CW'(1);
    assign w_nb       = BORDER && ((w_nrow == '0) || (w_nrow == RW'(PH - 1)) ||
                                   (w_ncol == '0) || (w_ncol == CW'(PW - 1)));
    assign w_pix      = r_p1_zero ? '0 : bus.rd_data;
    assign w_win_ok   = (r_p1_row >= RW'(2)) && (r_p1_col >= CW'(2));
    assign w_orow     = r_p1_row - RW'(2);
    assign w_ocol     = r_p1_col - CW'(2);

    // Scan sequencer: row/col counters, read strobe/address, busy/done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_issue   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_zero    <= 1'b0;
            r_rd_addr <= '0;
            r_drain   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.en) begin
                        r_state   <= S_SCAN;
                        r_busy    <= 1'b1;
                        r_issue   <= 1'b1;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_rd_en   <= !BORDER;
                        r_zero    <= BORDER;
                        r_rd_addr <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_last) begin
                        r_state   <= S_DRAIN;
                        r_issue   <= 1'b0;
                        r_rd_en   <= 1'b0;
                        r_zero    <= 1'b0;
                        r_rd_addr <= '0;
                        r_drain   <= 1'b1;
                    end else begin
                        r_row     <= w_nrow;
                        r_col     <= w_ncol;
                        r_rd_en   <= !w_nb;
                        r_zero    <= w_nb;
                        // address only advances past positions that really read
                        r_rd_addr <= r_rd_addr + AW'(r_rd_en);
                    end
                end
                S_DRAIN: begin
                    if (r_drain == 1'b0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Next window: shift left one column, new column enters on the right.
    always_comb begin
        w_sh_next = r_sh;
        for (int rr = 0; rr < 3; rr++) begin
            w_sh_next[(rr*3+0)*DW +: DW] = r_sh[(rr*3+1)*DW +: DW];
            w_sh_next[(rr*3+1)*DW +: DW] = r_sh[(rr*3+2)*DW +: DW];
        end
        w_sh_next[2*DW +: DW] = r_lb0[r_p1_col];
        w_sh_next[5*DW +: DW] = r_lb1[r_p1_col];
        w_sh_next[8*DW +: DW] = w_pix;
    end

    // Arrival stage: track the issued index and register the window outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p1_vld    <= 1'b0;
            r_p1_zero   <= 1'b0;
            r_p1_row    <= '0;
            r_p1_col    <= '0;
            r_sh        <= '0;
            r_win       <= '0;
            r_win_valid <= 1'b0;
            r_out_row   <= '0;
            r_out_col   <= '0;
        end else begin
            r_p1_vld  <= r_issue;
            r_p1_zero <= r_zero;
            r_p1_row  <= r_row;
            r_p1_col  <= r_col;
            if (r_p1_vld) begin
                r_sh <= w_sh_next;
            end
            // columns 0/1 and rows 0/1 only prime the window, never emitted
            if (r_p1_vld && w_win_ok) begin
                r_win_valid <= 1'b1;
                r_win       <= w_sh_next;
                r_out_row   <= 8'(w_orow);
                r_out_col   <= 8'(w_ocol);
            end else begin
                r_win_valid <= 1'b0;
                r_win       <= '0;
                r_out_row   <= '0;
                r_out_col   <= '0;
            end
        end
    end

    // Line buffers: lb0 holds row r-2, lb1 holds row r-1 per padded column.
    always_ff @(posedge clk) begin
        if (r_p1_vld) begin
            r_lb0[r_p1_col] <= r_lb1[r_p1_col];
            r_lb1[r_p1_col] <= w_pix;
        end
    end

    assign bus.rd_en     = r_rd_en;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.win       = r_win;
    assign bus.win_valid = r_win_valid;
    assign bus.out_row   = r_out_row;
    assign bus.out_col   = r_out_col;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule
